// File: rtl/fft_agu_ctrl_pkg.sv
// Shared definitions for the FFT address-generation controller.
package fft_agu_ctrl_pkg;

  localparam int N_LOG2_DEF     = 10;
  localparam int MEM_RD_LAT_DEF = 1;
  localparam int BF_LAT_DEF     = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } agu_state_t;

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth shift register with synchronous clear; output is the last stage.
module fft_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] pipe;

  // Shift one stage per cycle; reset flushes everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/fft_agu_ctrl.sv
// Radix-2 DIT FFT sequencer: issues butterfly read/twiddle addresses and
// replays them LAT cycles later as in-place write-back addresses.
module fft_agu_ctrl
  import fft_agu_ctrl_pkg::*;
#(
  parameter int N_LOG2     = N_LOG2_DEF,
  parameter int MEM_RD_LAT = MEM_RD_LAT_DEF,
  parameter int BF_LAT     = BF_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_LOG2-1:0] scale_mask,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [N_LOG2-1:0] mem_rd_addra,
  output logic [N_LOG2-1:0] mem_rd_addrb,
  output logic [N_LOG2-2:0] tw_addr,
  output logic              scale,
  output logic              mem_wr_en,
  output logic [N_LOG2-1:0] mem_wr_addra,
  output logic [N_LOG2-1:0] mem_wr_addrb
);

  localparam int LAT = MEM_RD_LAT + BF_LAT;
  localparam int JW  = N_LOG2 - 1;
  localparam int SW  = $clog2(N_LOG2 + 1);
  localparam int CW  = $clog2(LAT + 1);
  localparam int WBW = 2 + 2 * N_LOG2;

  localparam logic [JW-1:0] J_LAST = '1;
  localparam logic [SW-1:0] S_LAST = SW'(N_LOG2 - 1);
  localparam logic [CW-1:0] C_LAST = CW'(LAT - 1);

  // Top address: clear bit s of j's position by shifting the group bits up one.
  function automatic logic [N_LOG2-1:0] bf_addra(input logic [JW-1:0] jj,
                                                 input logic [SW-1:0] ss);
    logic [N_LOG2-1:0] jw, lo;
    jw = {1'b0, jj};
    lo = (N_LOG2'(1) << ss) - N_LOG2'(1);
    return ((jw & ~lo) << 1) | (jw & lo);
  endfunction

  function automatic logic [N_LOG2-2:0] bf_tw(input logic [JW-1:0] jj,
                                              input logic [SW-1:0] ss);
    logic [N_LOG2-1:0] jw, lo, t;
    jw = {1'b0, jj};
    lo = (N_LOG2'(1) << ss) - N_LOG2'(1);
    t  = (jw & lo) << ((N_LOG2 - 1) - int'(ss));
    return t[N_LOG2-2:0];
  endfunction

  agu_state_t        state;
  logic [JW-1:0]     j;
  logic [SW-1:0]     s;
  logic [CW-1:0]     dcnt;
  logic [N_LOG2-1:0] mask_q;
  logic              rd_scl;

  logic              iss_en;
  logic [JW-1:0]     iss_j;
  logic [SW-1:0]     iss_s;
  logic [N_LOG2-1:0] mask_src;

  // Next butterfly to issue (if any) given the current state and counters.
  always_comb begin
    iss_en = 1'b0;
    iss_j  = j;
    iss_s  = s;
    case (state)
      ST_IDLE:  if (start) begin
                  iss_en = 1'b1;
                  iss_j  = '0;
                  iss_s  = '0;
                end
      ST_RUN:   if (j != J_LAST) begin
                  iss_en = 1'b1;
                  iss_j  = j + JW'(1);
                end
      ST_DRAIN: if (dcnt == C_LAST && s != S_LAST) begin
                  iss_en = 1'b1;
                  iss_j  = '0;
                  iss_s  = s + SW'(1);
                end
      default: ;
    endcase
    // The mask is only captured on the start edge, so stage 0 reads it live.
    mask_src = (state == ST_IDLE) ? scale_mask : mask_q;
  end

  // Sequencer: state, counters and registered read-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      j            <= '0;
      s            <= '0;
      dcnt         <= '0;
      mask_q       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      mem_rd_en    <= 1'b0;
      mem_rd_addra <= '0;
      mem_rd_addrb <= '0;
      tw_addr      <= '0;
      rd_scl       <= 1'b0;
    end else begin
      j         <= iss_j;
      s         <= iss_s;
      mem_rd_en <= iss_en;
      rd_scl    <= iss_en & mask_src[iss_s];
      done      <= 1'b0;
      if (iss_en) begin
        mem_rd_addra <= bf_addra(iss_j, iss_s);
        mem_rd_addrb <= bf_addra(iss_j, iss_s) + (N_LOG2'(1) << iss_s);
        tw_addr      <= bf_tw(iss_j, iss_s);
      end
      case (state)
        ST_IDLE: if (start) begin
          state  <= ST_RUN;
          mask_q <= scale_mask;
          busy   <= 1'b1;
        end
        ST_RUN: if (j == J_LAST) begin
          state <= ST_DRAIN;
          dcnt  <= '0;
        end
        ST_DRAIN: begin
          if (dcnt == C_LAST) begin
            dcnt <= '0;
            if (s == S_LAST) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end else begin
            dcnt <= dcnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic [WBW-1:0] wb_in, wb_out;

  assign wb_in = {mem_rd_en, mem_rd_addra, mem_rd_addrb, rd_scl};

  fft_delay_line #(.WIDTH(WBW), .DEPTH(LAT)) u_wb_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (wb_in),
    .dout (wb_out)
  );

  assign {mem_wr_en, mem_wr_addra, mem_wr_addrb, scale} = wb_out;

endmodule

// File: tb/tb_fft_agu_ctrl.sv
// Directed bench for fft_agu_ctrl at N=8 (N_LOG2=3), LAT=6.
module tb_fft_agu_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] scale_mask;
  logic       busy, done, mem_rd_en, scale, mem_wr_en;
  logic [2:0] mem_rd_addra, mem_rd_addrb, mem_wr_addra, mem_wr_addrb;
  logic [1:0] tw_addr;

  int nchk = 0;
  int nerr = 0;

  // Hand-derived butterfly tables per stage: top, bottom, twiddle.
  int unsigned ta [3][4] = '{'{0,2,4,6}, '{0,1,4,5}, '{0,1,2,3}};
  int unsigned tb [3][4] = '{'{1,3,5,7}, '{2,3,6,7}, '{4,5,6,7}};
  int unsigned ttw[3][4] = '{'{0,0,0,0}, '{0,2,0,2}, '{0,1,2,3}};

  fft_agu_ctrl #(.N_LOG2(3), .MEM_RD_LAT(1), .BF_LAT(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .scale_mask   (scale_mask),
    .busy         (busy),
    .done         (done),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addra (mem_rd_addra),
    .mem_rd_addrb (mem_rd_addrb),
    .tw_addr      (tw_addr),
    .scale        (scale),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_addra (mem_wr_addra),
    .mem_wr_addrb (mem_wr_addrb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; scale_mask = '0;
    tick(); tick(); tick();
    nchk++;
    if ({busy, done, mem_rd_en, mem_wr_en, scale} !== 5'b0) begin
      nerr++;
      $display("FAIL reset_ctrl: got %b want 00000", {busy, done, mem_rd_en, mem_wr_en, scale});
    end
    nchk++;
    if ({mem_rd_addra, mem_rd_addrb, tw_addr, mem_wr_addra, mem_wr_addrb} !== 14'b0) begin
      nerr++;
      $display("FAIL reset_addr: got %h want 0",
               {mem_rd_addra, mem_rd_addrb, tw_addr, mem_wr_addra, mem_wr_addrb});
    end
    rst = 1'b0;
    tick();
  endtask

  // Entry: caller is in an idle cycle, which becomes cycle 0 of the transform.
  task automatic test_transform(input logic [2:0] mask, input bit hold, input string tag);
    int st, k;
    bit e_busy, e_done, e_rd, e_wr;
    start = 1'b1;
    scale_mask = mask;
    for (int c = 1; c <= 31; c++) begin
      tick();
      if (!hold) start = 1'b0;
      scale_mask = ~mask;  // must have been captured on start
      st = (c - 1) / 10;
      k  = (c - 1) % 10;
      e_busy = (c <= 30);
      e_done = (c == 31);
      e_rd   = (c <= 30) && (k < 4);
      e_wr   = (c <= 30) && (k >= 6);
      nchk++;
      if (busy !== e_busy || done !== e_done) begin
        nerr++;
        $display("FAIL %s busy_done c%0d: got %b%b want %b%b", tag, c, busy, done, e_busy, e_done);
      end
      nchk++;
      if (mem_rd_en !== e_rd) begin
        nerr++;
        $display("FAIL %s rd_en c%0d: got %b want %b", tag, c, mem_rd_en, e_rd);
      end
      nchk++;
      if (mem_wr_en !== e_wr) begin
        nerr++;
        $display("FAIL %s wr_en c%0d: got %b want %b", tag, c, mem_wr_en, e_wr);
      end
      if (e_rd) begin
        nchk++;
        if (mem_rd_addra !== 3'(ta[st][k]) || mem_rd_addrb !== 3'(tb[st][k]) ||
            tw_addr !== 2'(ttw[st][k])) begin
          nerr++;
          $display("FAIL %s rd_addr c%0d: got a=%0d b=%0d tw=%0d want a=%0d b=%0d tw=%0d",
                   tag, c, mem_rd_addra, mem_rd_addrb, tw_addr, ta[st][k], tb[st][k], ttw[st][k]);
        end
      end
      if (e_wr) begin
        nchk++;
        if (mem_wr_addra !== 3'(ta[st][k-6]) || mem_wr_addrb !== 3'(tb[st][k-6])) begin
          nerr++;
          $display("FAIL %s wr_addr c%0d: got a=%0d b=%0d want a=%0d b=%0d",
                   tag, c, mem_wr_addra, mem_wr_addrb, ta[st][k-6], tb[st][k-6]);
        end
        nchk++;
        if (scale !== mask[st]) begin
          nerr++;
          $display("FAIL %s scale c%0d: got %b want %b", tag, c, scale, mask[st]);
        end
      end else if (mask == 3'b000) begin
        nchk++;
        if (scale !== 1'b0) begin
          nerr++;
          $display("FAIL %s scale_idle c%0d: got %b want 0", tag, c, scale);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    test_transform(3'b011, 1'b1, "b2b_first");
    // Cycle 32: idle again with start still high -> becomes the next cycle 0.
    tick();
    nchk++;
    if (busy !== 1'b0 || done !== 1'b0 || mem_rd_en !== 1'b0) begin
      nerr++;
      $display("FAIL b2b_gap: got busy=%b done=%b rd=%b want 000", busy, done, mem_rd_en);
    end
    test_transform(3'b011, 1'b1, "b2b_second");
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    start = 1'b1; scale_mask = 3'b111;
    tick();           // cycle 1
    start = 1'b0;
    for (int c = 2; c <= 8; c++) tick();
    nchk++;
    if (mem_wr_en !== 1'b1 || busy !== 1'b1) begin
      nerr++;
      $display("FAIL midrst_pre: got wr=%b busy=%b want 11", mem_wr_en, busy);
    end
    rst = 1'b1;
    tick();           // cycle 9
    rst = 1'b0;
    nchk++;
    if ({busy, done, mem_rd_en, mem_wr_en, scale, mem_rd_addra, mem_rd_addrb, tw_addr,
         mem_wr_addra, mem_wr_addrb} !== 19'b0) begin
      nerr++;
      $display("FAIL midrst_outputs: got %h want 0",
               {busy, done, mem_rd_en, mem_wr_en, scale, mem_rd_addra, mem_rd_addrb, tw_addr,
                mem_wr_addra, mem_wr_addrb});
    end
    for (int c = 10; c <= 40; c++) begin
      tick();
      nchk++;
      if (mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        nerr++;
        $display("FAIL midrst_quiet c%0d: got wr=%b rd=%b busy=%b done=%b want 0000",
                 c, mem_wr_en, mem_rd_en, busy, done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_transform(3'b000, 1'b0, "mask000");
    tick(); tick();
    test_transform(3'b101, 1'b0, "mask101");
    tick();
    test_back_to_back();
    test_reset_mid();
    test_transform(3'b010, 1'b0, "after_rst");
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
